wheel_speed_sched: RTL and testbench
====================================

// Module: wheel_speed_sched
// PURPOSE
//  Sequencer for the car's two-wheel speed path. Generates the measurement window
//  from clk, counts synchronised encoder pulses per wheel, then scales both counts
//  through one shared multiplier (A, then B) and converts the selected wheel to
//  4 BCD digits for the seven-segment driver. Also flags stalled wheels.
// PARAMETERS
//  CLK_HZ     50_000_000  clk frequency in Hz
//  GATE_MS    1000        window length in ms; GATE_CYC = CLK_HZ/1000*GATE_MS, must be >= 32
//  SCALE      176         count-to-speed factor (speed = count*SCALE)
//  CNT_W      14          raw pulse counter width, saturating
//  STALL_WIN  4           consecutive zero-count windows that set the stall flag
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous reset, active-high
//  enc_a     in   1      wheel A encoder pulse, asynchronous
//  enc_b     in   1      wheel B encoder pulse, asynchronous
//  sel       in   1      display channel: 0 = wheel A, 1 = wheel B
//  win_end   out  1      one-cycle pulse on the last cycle of each window
//  speed_a   out  14     scaled wheel A speed, saturated at 9999
//  speed_b   out  14     scaled wheel B speed, saturated at 9999
//  AX,BX,CX,DX out 4 each  BCD thousands/hundreds/tens/units of the selected speed
//  valid     out  1      one-cycle pulse when the outputs above update
//  stall_a   out  1      wheel A stalled
//  stall_b   out  1      wheel B stalled
//  ovf       out  1      last window saturated on either wheel (counter or 9999 cap)
// BEHAVIOUR
//  - Reset: all outputs 0; counters, timer and stall counts 0; FSM in COUNT. This holds mid-conversion too.
//  - Encoders: 2-FF synchroniser, then rising-edge detect. Pulses must be >= 2 clk high and >= 2 clk low.
//  - Timer: free-running 0..GATE_CYC-1. win_end = (timer == GATE_CYC-1).
//  - Counting never stops. On the win_end edge: snap_x <= cnt_x + edge_x, saturated at 2^CNT_W-1,
//    and cnt_x <= 0. An edge on the last window cycle counts in the closing window.
//    An edge on the first cycle of the next window counts in the new window.
//  - FSM: COUNT -> MUL_A -> MUL_B -> CONV(14 cycles) -> UPD -> COUNT.
//    It leaves COUNT only on win_end.
//  - MUL_x: one shared multiplier computes snap_x*SCALE as a 24-bit value. If the product
//    exceeds 9999, res_x = 9999 and ovf_pend is set; otherwise res_x = product.
//  - sel is sampled on entry to CONV. Changes during CONV or UPD take effect in the next window.
//  - CONV: shift-add-3 binary-to-BCD conversion of res_sel, 14 iterations, one per cycle.
//  - UPD edge is the 17th clock edge after the win_end edge. On it speed_a, speed_b,
//    AX..DX, ovf and stall_x update together, and valid goes high for exactly one cycle.
//  - Stall: zcnt_x increments (saturating) when snap_x == 0 and clears otherwise.
//    stall_x = (zcnt_x >= STALL_WIN). While the selected wheel is stalled, AX..DX are forced to 0.
//  - GATE_CYC >= 32 guarantees UPD precedes the next win_end. No overlap handling is required.
// TESTING
//  Bench parameters: CLK_HZ=1000, GATE_MS=100 (GATE_CYC=100).
//  1. 10 enc_a pulses in one window, sel=0 -> at win_end+17: speed_a=1760, AX..DX=1,7,6,0,
//     valid high 1 cycle, ovf=0.
//  2. 57 enc_b pulses, sel=1 -> speed_b=9999, AX..DX=9,9,9,9, ovf=1.
//     Next window with 3 pulses -> 528, ovf=0.
//  3. enc_a pulse on the win_end cycle and one on the next cycle -> closing window count 1,
//     next window count 1 (speed_a=176 twice).
//  4. No enc_a pulses for 4 windows -> stall_a=1 at 4th valid, digits 0.
//     One pulse in 5th window -> stall_a=0, speed_a=176.
//  5. Toggle sel 5 cycles after win_end -> that window shows the old channel;
//     the following window shows the new channel.
//  6. Assert rst during CONV -> all outputs 0 immediately, no valid pulse.
//     After release, first valid arrives at the first win_end + 17.

Source files
------------

// File: rtl/wheel_speed_sched.sv
// Two-wheel speed sequencer: window timer, synchronised pulse counters, one shared
// scaling multiplier, serial binary-to-BCD conversion and stall detection.
module wheel_speed_sched #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int GATE_MS   = 1000,
  parameter int SCALE     = 176,
  parameter int CNT_W     = 14,
  parameter int STALL_WIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        sel,
  output logic        win_end,
  output logic [13:0] speed_a,
  output logic [13:0] speed_b,
  output logic [3:0]  AX,
  output logic [3:0]  BX,
  output logic [3:0]  CX,
  output logic [3:0]  DX,
  output logic        valid,
  output logic        stall_a,
  output logic        stall_b,
  output logic        ovf
);

  localparam int GATE_CYC = CLK_HZ / 1000 * GATE_MS;
  localparam int TW       = $clog2(GATE_CYC);
  localparam int ZW       = $clog2(STALL_WIN + 1);
  localparam logic [TW-1:0]    T_LAST  = TW'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ZW-1:0]    Z_MAX   = '1;
  localparam logic [23:0]      CAP     = 24'd9999;

  typedef enum logic [2:0] {S_COUNT, S_MUL_A, S_MUL_B, S_CONV, S_UPD} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
    return (e && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  function automatic logic [ZW-1:0] zero_run(input logic [ZW-1:0] z, input logic is_zero);
    if (!is_zero)        return '0;
    else if (z == Z_MAX) return z;
    else                 return z + ZW'(1);
  endfunction

  // {bcd[15:0], bin[13:0]}: add 3 to every BCD digit >= 5, then shift left by one
  function automatic logic [29:0] bcd_step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
      else                        t[14+4*i +: 4] = t[14+4*i +: 4];
    end
    return {t[28:0], 1'b0};
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        sync_a_q, sync_b_q;
  logic              prev_a_q, prev_b_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic              win_end_q;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]  snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [13:0]       res_a_q, res_a_d, res_b_q, res_b_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              sel_q, sel_d;
  logic [29:0]       shf_q, shf_d;
  logic [3:0]        it_q, it_d;
  logic [ZW-1:0]     zcnt_a_q, zcnt_a_d, zcnt_b_q, zcnt_b_d;
  logic [13:0]       speed_a_q, speed_a_d, speed_b_q, speed_b_d;
  logic [15:0]       dig_q, dig_d;
  logic              valid_q, valid_d, stall_a_q, stall_a_d, stall_b_q, stall_b_d, ovf_q, ovf_d;
  logic              edg_a_s, edg_b_s, prod_ovf_s;
  logic [CNT_W-1:0]  mul_in_s;
  logic [23:0]       prod_s;
  logic [13:0]       res_sat_s;

  assign edg_a_s    = sync_a_q[1] & ~prev_a_q;
  assign edg_b_s    = sync_b_q[1] & ~prev_b_q;
  assign mul_in_s   = (state_q == S_MUL_A) ? snap_a_q : snap_b_q;
  assign prod_s     = 24'(mul_in_s) * 24'(SCALE);
  assign prod_ovf_s = (prod_s > CAP);
  assign res_sat_s  = prod_ovf_s ? 14'd9999 : prod_s[13:0];

  // Window timer and pulse counters; an edge on the closing cycle lands in the snapshot
  always_comb begin
    timer_d  = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
    cnt_a_d  = sat_inc(cnt_a_q, edg_a_s);
    cnt_b_d  = sat_inc(cnt_b_q, edg_b_s);
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    if (win_end_q) begin
      snap_a_d = cnt_a_d;
      snap_b_d = cnt_b_d;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
    end else begin
      snap_a_d = snap_a_q;
      snap_b_d = snap_b_q;
    end
  end

  // Sequencer next state and datapath
  always_comb begin
    state_d    = state_q;
    res_a_d    = res_a_q;
    res_b_d    = res_b_q;
    ovf_pend_d = ovf_pend_q;
    sel_d      = sel_q;
    shf_d      = shf_q;
    it_d       = it_q;
    zcnt_a_d   = zcnt_a_q;
    zcnt_b_d   = zcnt_b_q;
    speed_a_d  = speed_a_q;
    speed_b_d  = speed_b_q;
    dig_d      = dig_q;
    stall_a_d  = stall_a_q;
    stall_b_d  = stall_b_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      S_COUNT: begin
        if (win_end_q) begin
          state_d    = S_MUL_A;
          ovf_pend_d = (snap_a_d == CNT_MAX) | (snap_b_d == CNT_MAX);
        end else begin
          state_d    = S_COUNT;
        end
      end
      S_MUL_A: begin
        res_a_d    = res_sat_s;
        ovf_pend_d = ovf_pend_q | prod_ovf_s;
        state_d    = S_MUL_B;
      end
      S_MUL_B: begin
        res_b_d    = res_sat_s;
        ovf_pend_d = ovf_pend_q | prod_ovf_s;
        sel_d      = sel;
        shf_d      = {16'd0, (sel ? res_sat_s : res_a_q)};
        it_d       = 4'd0;
        state_d    = S_CONV;
      end
      S_CONV: begin
        shf_d = bcd_step(shf_q);
        it_d  = it_q + 4'd1;
        if (it_q == 4'd13) state_d = S_UPD;
        else               state_d = S_CONV;
      end
      S_UPD: begin
        zcnt_a_d  = zero_run(zcnt_a_q, snap_a_q == '0);
        zcnt_b_d  = zero_run(zcnt_b_q, snap_b_q == '0);
        stall_a_d = (zcnt_a_d >= ZW'(STALL_WIN));
        stall_b_d = (zcnt_b_d >= ZW'(STALL_WIN));
        speed_a_d = res_a_q;
        speed_b_d = res_b_q;
        dig_d     = (sel_q ? stall_b_d : stall_a_d) ? 16'd0 : shf_q[29:14];
        ovf_d     = ovf_pend_q;
        valid_d   = 1'b1;
        state_d   = S_COUNT;
      end
      default: state_d = S_COUNT;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COUNT;
      sync_a_q <= 2'd0;  sync_b_q <= 2'd0;  prev_a_q <= 1'b0;  prev_b_q <= 1'b0;
      timer_q <= '0;     win_end_q <= 1'b0;
      cnt_a_q <= '0;     cnt_b_q <= '0;     snap_a_q <= '0;    snap_b_q <= '0;
      res_a_q <= 14'd0;  res_b_q <= 14'd0;  ovf_pend_q <= 1'b0; sel_q <= 1'b0;
      shf_q <= 30'd0;    it_q <= 4'd0;      zcnt_a_q <= '0;    zcnt_b_q <= '0;
      speed_a_q <= 14'd0; speed_b_q <= 14'd0; dig_q <= 16'd0;
      valid_q <= 1'b0;   stall_a_q <= 1'b0; stall_b_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_a_q <= {sync_a_q[0], enc_a};  sync_b_q <= {sync_b_q[0], enc_b};
      prev_a_q <= sync_a_q[1];           prev_b_q <= sync_b_q[1];
      timer_q <= timer_d;  win_end_q <= (timer_d == T_LAST);
      cnt_a_q <= cnt_a_d;  cnt_b_q <= cnt_b_d;  snap_a_q <= snap_a_d;  snap_b_q <= snap_b_d;
      res_a_q <= res_a_d;  res_b_q <= res_b_d;  ovf_pend_q <= ovf_pend_d;  sel_q <= sel_d;
      shf_q <= shf_d;      it_q <= it_d;        zcnt_a_q <= zcnt_a_d;  zcnt_b_q <= zcnt_b_d;
      speed_a_q <= speed_a_d;  speed_b_q <= speed_b_d;  dig_q <= dig_d;
      valid_q <= valid_d;  stall_a_q <= stall_a_d;  stall_b_q <= stall_b_d;  ovf_q <= ovf_d;
    end
  end

  assign win_end          = win_end_q;
  assign speed_a          = speed_a_q;
  assign speed_b          = speed_b_q;
  assign {AX, BX, CX, DX} = dig_q;
  assign valid            = valid_q;
  assign stall_a          = stall_a_q;
  assign stall_b          = stall_b_q;
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_wheel_speed_sched.sv
// Directed bench for wheel_speed_sched; window stretched to 300 cycles so that 57
// pulses of legal width (2 high, 2 low) fit inside one window.
module tb_wheel_speed_sched;
  localparam int G = 300;

  logic clk = 1'b0;
  logic rst, enc_a, enc_b, sel;
  logic win_end, valid, stall_a, stall_b, ovf;
  logic [13:0] speed_a, speed_b;
  logic [3:0] AX, BX, CX, DX;

  int n_cmp = 0;
  int n_mis = 0;
  int tw = 0;
  bit seen_valid = 1'b0;

  wheel_speed_sched #(.CLK_HZ(1000), .GATE_MS(300), .SCALE(176), .CNT_W(14), .STALL_WIN(4)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .sel(sel),
    .win_end(win_end), .speed_a(speed_a), .speed_b(speed_b),
    .AX(AX), .BX(BX), .CX(CX), .DX(DX),
    .valid(valid), .stall_a(stall_a), .stall_b(stall_b), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tw = (tw + 1) % G;
    if (valid) seen_valid = 1'b1;
  endtask

  task automatic wait_win_end(output int n);
    n = 0;
    while (!win_end && n < 2 * G) begin
      tick();
      n++;
    end
    chk("win_end_seen", {31'd0, win_end}, 32'd1);
    chk("win_end_timer", tw, G - 1);
  endtask

  // Called on the last cycle of a window: checks that window's results, then drives the next one.
  task automatic step(input int na, input int nb, input int amode, input logic sel_now,
                      input logic sel_late, input int e_sa, input int e_sb,
                      input logic [15:0] e_dig, input logic e_ovf, input logic e_sta,
                      input logic e_stb);
    int m;
    int n;
    sel = sel_now;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) enc_a = 1'b0;
      if (k == 6) sel = sel_late;
    end
    chk("valid_before", {31'd0, valid}, 32'd0);
    tick();
    chk("valid_pulse", {31'd0, valid}, 32'd1);
    chk("speed_a", {18'd0, speed_a}, e_sa);
    chk("speed_b", {18'd0, speed_b}, e_sb);
    chk("digits", {16'd0, AX, BX, CX, DX}, {16'd0, e_dig});
    chk("ovf", {31'd0, ovf}, {31'd0, e_ovf});
    chk("stall_a", {31'd0, stall_a}, {31'd0, e_sta});
    chk("stall_b", {31'd0, stall_b}, {31'd0, e_stb});
    tick();
    chk("valid_after", {31'd0, valid}, 32'd0);
    m = (na > nb) ? na : nb;
    for (int i = 0; i < m; i++) begin
      enc_a = (i < na);
      enc_b = (i < nb);
      tick(); tick();
      enc_a = 1'b0;
      enc_b = 1'b0;
      tick(); tick();
    end
    if (amode == 1) begin
      while (tw != G - 3) tick();
      enc_a = 1'b1;
      tick(); tick();
      enc_a = 1'b0;
    end else if (amode == 2) begin
      while (tw != G - 2) tick();
      enc_a = 1'b1;
      tick();
    end
    wait_win_end(n);
  endtask

  initial begin
    int n;
    rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_speed_a", {18'd0, speed_a}, 32'd0);
    chk("rst_digits", {16'd0, AX, BX, CX, DX}, 32'd0);
    chk("rst_flags", {27'd0, win_end, valid, stall_a, stall_b, ovf}, 32'd0);
    rst = 1'b0;
    tw = 0;
    wait_win_end(n);
    chk("first_window_len", n, G - 1);

    step(10, 1, 0, 1'b0, 1'b0,    0,    0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step( 1, 57, 0, 1'b0, 1'b0, 1760,  176, 16'h1760, 1'b0, 1'b0, 1'b0);
    step( 1, 3, 0, 1'b1, 1'b1,  176, 9999, 16'h9999, 1'b1, 1'b0, 1'b0);
    step( 0, 1, 1, 1'b1, 1'b1,  176,  528, 16'h0528, 1'b0, 1'b0, 1'b0);
    step( 1, 1, 2, 1'b0, 1'b0,  176,  176, 16'h0176, 1'b0, 1'b0, 1'b0);
    step( 0, 1, 0, 1'b0, 1'b0,  176,  176, 16'h0176, 1'b0, 1'b0, 1'b0);
    step( 0, 1, 0, 1'b0, 1'b0,  176,  176, 16'h0176, 1'b0, 1'b0, 1'b0);
    step( 0, 1, 0, 1'b0, 1'b0,    0,  176, 16'h0000, 1'b0, 1'b0, 1'b0);
    step( 0, 1, 0, 1'b0, 1'b0,    0,  176, 16'h0000, 1'b0, 1'b0, 1'b0);
    step( 0, 1, 0, 1'b0, 1'b0,    0,  176, 16'h0000, 1'b0, 1'b0, 1'b0);
    step( 1, 1, 0, 1'b0, 1'b0,    0,  176, 16'h0000, 1'b0, 1'b1, 1'b0);
    step( 2, 4, 0, 1'b0, 1'b0,  176,  176, 16'h0176, 1'b0, 1'b0, 1'b0);
    step( 2, 4, 0, 1'b0, 1'b1,  352,  704, 16'h0352, 1'b0, 1'b0, 1'b0);
    step( 3, 0, 0, 1'b1, 1'b1,  352,  704, 16'h0704, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the BCD conversion of the window just closed
    repeat (8) tick();
    chk("pre_rst_speed_b", {18'd0, speed_b}, 32'd704);
    rst = 1'b1;
    #1;
    chk("rst_conv_speeds", {4'd0, speed_a, speed_b}, 32'd0);
    chk("rst_conv_digits", {16'd0, AX, BX, CX, DX}, 32'd0);
    chk("rst_conv_flags", {27'd0, win_end, valid, stall_a, stall_b, ovf}, 32'd0);
    seen_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tw = 0;
    wait_win_end(n);
    chk("post_rst_window_len", n, G - 1);
    chk("post_rst_no_valid", {31'd0, seen_valid}, 32'd0);
    step(0, 0, 0, 1'b0, 1'b0, 0, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
